// File: rtl/eink_pkg.sv
// Shared types and constants for the e-ink SPI engine: FSM states, default
// parameter values and the display controller opcodes the firmware sends.
package eink_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRstLo,
    StRstWait,
    StShift,
    StGap,
    StBusyWait
  } state_e;

  localparam int unsigned DefClkDiv      = 4;
  localparam int unsigned DefNumCs       = 2;
  localparam int unsigned DefRstCycles   = 1000;
  localparam int unsigned DefBusyTimeout = 65535;

  localparam logic [7:0] OpDriverOutput = 8'h01;
  localparam logic [7:0] OpSwReset      = 8'h12;
  localparam logic [7:0] OpMasterAct    = 8'h20;
  localparam logic [7:0] OpWriteRam     = 8'h24;

endpackage

// File: rtl/eink_spi_shifter.sv
// SPI mode-0 byte shifter: divides clk into SCK half-periods of 'div' clocks and
// sends one byte MSB first over 16 half-periods, pulsing 'done' on the last clock.
module eink_spi_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  data_byte,
  input  logic [15:0] div,
  output logic        sck,
  output logic        mosi,
  output logic        done
);

  logic        active_q;
  logic [15:0] div_cnt_q;
  logic [3:0]  half_q;
  logic [6:0]  sh_q;
  logic        sck_q;
  logic        mosi_q;
  logic        half_end;

  assign half_end = active_q && (div_cnt_q == div - 16'd1);
  assign done     = half_end && (half_q == 4'd15);
  assign sck      = sck_q;
  assign mosi     = mosi_q;

  // Even half-periods are SCK low, odd are SCK high; MOSI moves on falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      div_cnt_q <= '0;
      half_q    <= '0;
      sh_q      <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else if (load) begin
      active_q  <= 1'b1;
      div_cnt_q <= '0;
      half_q    <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= data_byte[7];
      sh_q      <= data_byte[6:0];
    end else if (active_q) begin
      if (half_end) begin
        div_cnt_q <= '0;
        half_q    <= half_q + 4'd1;
        sck_q     <= ~half_q[0];
        if (half_q[0] && !done) begin
          mosi_q <= sh_q[6];
          sh_q   <= {sh_q[5:0], 1'b0};
        end
        if (done) begin
          active_q <= 1'b0;
        end
      end else begin
        div_cnt_q <= div_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/eink_spi_engine.sv
// E-ink panel SPI engine: byte stream with D/C and chip-select control, display
// reset pulse and busy wait. Optional pin passthrough under EINK_PASSTHRU_EN.
module eink_spi_engine
  import eink_pkg::*;
#(
  parameter int unsigned CLK_DIV      = DefClkDiv,
  parameter int unsigned NUM_CS       = DefNumCs,
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned BUSY_TIMEOUT = DefBusyTimeout,
  localparam int unsigned CsW         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_dc,
  input  logic [CsW-1:0]    in_cs,
  input  logic              in_last,
  input  logic              in_wait,
  input  logic              start_reset,
  output logic              sck,
  output logic              mosi,
  output logic              dcb,
  output logic [NUM_CS-1:0] csb,
  output logic              resetb,
  input  logic              busy,
  output logic              idle,
  output logic              timeout
`ifdef EINK_PASSTHRU_EN
  ,
  input  logic              pt_en,
  input  logic              pt_sck,
  input  logic              pt_mosi,
  input  logic              pt_dc,
  input  logic              pt_csb
`endif
);

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_CS-1:0]   csb_q, csb_d;
  logic                dcb_q, dcb_d;
  logic                resetb_q, resetb_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          data_q, data_d;
  logic                dc_q, dc_d;
  logic [CsW-1:0]      cs_q, cs_d;
  logic                last_q, last_d;
  logic                wait_q, wait_d;
  logic                held_q, held_d;
  logic                pend_q, pend_d;
  logic                busy_s1_q, busy_s2_q;
  logic                shift_load;
  logic [7:0]          shift_data;
  logic                shift_done;
  logic                sck_eng, mosi_eng;
  logic                accept;
  logic                blocked;

  eink_spi_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (shift_load),
    .data_byte (shift_data),
    .div       (16'(CLK_DIV)),
    .sck       (sck_eng),
    .mosi      (mosi_eng),
    .done      (shift_done)
  );

`ifdef EINK_PASSTHRU_EN
  logic pt_active;
  assign pt_active = pt_en && (state_q == StIdle);
  assign blocked   = pt_active;
`else
  assign blocked   = 1'b0;
`endif

  assign idle     = (state_q == StIdle);
  assign in_ready = idle && !start_reset && !blocked;
  assign accept   = in_valid && in_ready;
  assign timeout  = timeout_q;
  assign resetb   = resetb_q;
  assign cnt_inc  = cnt_q + 32'd1;

  always_comb begin
    sck  = sck_eng;
    mosi = mosi_eng;
    dcb  = dcb_q;
    csb  = csb_q;
`ifdef EINK_PASSTHRU_EN
    if (pt_active) begin
      sck    = pt_sck;
      mosi   = pt_mosi;
      dcb    = pt_dc;
      csb[0] = pt_csb;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    csb_d      = csb_q;
    dcb_d      = dcb_q;
    resetb_d   = resetb_q;
    timeout_d  = timeout_q;
    data_d     = data_q;
    dc_d       = dc_q;
    cs_d       = cs_q;
    last_d     = last_q;
    wait_d     = wait_q;
    held_d     = held_q;
    pend_d     = pend_q;
    shift_load = 1'b0;
    shift_data = in_data;

    case (state_q)
      StIdle: begin
        if (start_reset) begin
          state_d  = StRstLo;
          resetb_d = 1'b0;
          cnt_d    = '0;
        end else if (accept) begin
          timeout_d = 1'b0;
          data_d    = in_data;
          dc_d      = in_dc;
          cs_d      = in_cs;
          last_d    = in_last;
          wait_d    = in_wait;
          if (held_q && (in_cs != cs_q)) begin
            // Switching targets: drop the old CS for one gap before shifting.
            csb_d   = '1;
            held_d  = 1'b0;
            pend_d  = 1'b1;
            cnt_d   = '0;
            state_d = StGap;
          end else begin
            dcb_d = in_dc;
            if (32'(in_cs) < NUM_CS) begin
              csb_d[in_cs] = 1'b0;
            end
            shift_load = 1'b1;
            state_d    = StShift;
          end
        end
      end

      StRstLo: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= RST_CYCLES) begin
          resetb_d = 1'b1;
          cnt_d    = '0;
          state_d  = StRstWait;
        end
      end

      StRstWait: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= RST_CYCLES) begin
          cnt_d   = '0;
          state_d = StBusyWait;
        end
      end

      StShift: begin
        if (shift_done) begin
          cnt_d   = '0;
          state_d = StGap;
          if (last_q) begin
            csb_d  = '1;
            held_d = 1'b0;
          end else begin
            held_d = 1'b1;
          end
        end
      end

      StGap: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= CLK_DIV) begin
          cnt_d = '0;
          if (pend_q) begin
            pend_d = 1'b0;
            dcb_d  = dc_q;
            if (32'(cs_q) < NUM_CS) begin
              csb_d[cs_q] = 1'b0;
            end
            shift_load = 1'b1;
            shift_data = data_q;
            state_d    = StShift;
          end else if (wait_q) begin
            state_d = StBusyWait;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StBusyWait: begin
        if (!busy_s2_q) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_inc >= BUSY_TIMEOUT) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      csb_q     <= '1;
      dcb_q     <= 1'b0;
      resetb_q  <= 1'b1;
      timeout_q <= 1'b0;
      data_q    <= '0;
      dc_q      <= 1'b0;
      cs_q      <= '0;
      last_q    <= 1'b0;
      wait_q    <= 1'b0;
      held_q    <= 1'b0;
      pend_q    <= 1'b0;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      csb_q     <= csb_d;
      dcb_q     <= dcb_d;
      resetb_q  <= resetb_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
      dc_q      <= dc_d;
      cs_q      <= cs_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      held_q    <= held_d;
      pend_q    <= pend_d;
      busy_s1_q <= busy;
      busy_s2_q <= busy_s1_q;
    end
  end

endmodule

// File: tb/tb_eink_spi_engine.sv
// Bench for eink_spi_engine: SPI slave model captures bytes, directed and random
// transfers are compared against the bytes, D/C and chip selects that were sent.
module tb_eink_spi_engine;
  import eink_pkg::*;

  localparam int unsigned ClkDiv  = 4;
  localparam int unsigned NumCs   = 2;
  localparam int unsigned RstCyc  = 10;
  localparam int unsigned BusyTo  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_dc = 1'b0;
  logic [0:0] in_cs = '0;
  logic       in_last = 1'b0;
  logic       in_wait = 1'b0;
  logic       start_reset = 1'b0;
  logic       sck, mosi, dcb, resetb, idle, timeout;
  logic [1:0] csb;
  logic       busy = 1'b0;
`ifdef EINK_PASSTHRU_EN
  logic       pt_en = 1'b0, pt_sck = 1'b0, pt_mosi = 1'b0, pt_dc = 1'b0, pt_csb = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  eink_spi_engine #(
    .CLK_DIV      (ClkDiv),
    .NUM_CS       (NumCs),
    .RST_CYCLES   (RstCyc),
    .BUSY_TIMEOUT (BusyTo)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dc       (in_dc),
    .in_cs       (in_cs),
    .in_last     (in_last),
    .in_wait     (in_wait),
    .start_reset (start_reset),
    .sck         (sck),
    .mosi        (mosi),
    .dcb         (dcb),
    .csb         (csb),
    .resetb      (resetb),
    .busy        (busy),
    .idle        (idle),
    .timeout     (timeout)
`ifdef EINK_PASSTHRU_EN
    ,
    .pt_en       (pt_en),
    .pt_sck      (pt_sck),
    .pt_mosi     (pt_mosi),
    .pt_dc       (pt_dc),
    .pt_csb      (pt_csb)
`endif
  );

  always #5 clk = ~clk;

  // SPI slave: sample MOSI on SCK rising while any chip select is low.
  logic [7:0] slave_sh = '0;
  int         slave_bits = 0;
  int         sck_edges = 0;
  logic [7:0] cap_data[$];
  logic       cap_dc[$];
  logic [1:0] cap_cs[$];

  always @(posedge sck or posedge rst) begin
    if (rst) begin
      slave_bits = 0;
    end else if (csb != 2'b11) begin
      sck_edges++;
      slave_sh = {slave_sh[6:0], mosi};
      slave_bits++;
      if (slave_bits == 8) begin
        cap_data.push_back(slave_sh);
        cap_dc.push_back(dcb);
        cap_cs.push_back(csb);
        slave_bits = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic dc, input logic cs,
                      input logic last, input logic wt);
    int n;
    @(negedge clk);
    in_data  = d;
    in_dc    = dc;
    in_cs    = cs;
    in_last  = last;
    in_wait  = wt;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int nidle, output int lo, output int hi);
    nidle = 0;
    lo = 0;
    hi = 0;
    @(negedge clk);
    while (!idle && nidle < 5000) begin
      nidle++;
      if (!csb[0]) lo++;
      else hi++;
      @(negedge clk);
    end
    check("idle_reached", 32'(idle), 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic dc,
                             input logic [1:0] cs);
    check({tag, "_present"}, 32'(cap_data.size() > 0), 32'd1);
    if (cap_data.size() > 0) begin
      check({tag, "_data"}, 32'(cap_data.pop_front()), 32'(d));
      check({tag, "_dc"}, 32'(cap_dc.pop_front()), 32'(dc));
      check({tag, "_cs"}, 32'(cap_cs.pop_front()), 32'(cs));
    end
  endtask

  task automatic reset_seq(input int hold, output int rlow, output int nidle);
    int cyc;
    rlow = 0;
    nidle = 0;
    cyc = 0;
    @(negedge clk);
    start_reset = 1'b1;
    busy = (hold > 0);
    @(negedge clk);
    start_reset = 1'b0;
    while (!idle && nidle < 5000) begin
      if (!resetb) rlow++;
      nidle++;
      cyc++;
      if (hold > 0 && cyc >= hold) busy = 1'b0;
      @(negedge clk);
    end
    check("rst_idle_reached", 32'(idle), 32'd1);
  endtask

  initial begin
    int n, lo, hi, e0, rlow, nid;
    logic [7:0] d;
    logic dc, cs, last;
`ifdef EINK_PASSTHRU_EN
    logic [7:0] pat;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_csb", 32'(csb), 32'h3);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_resetb", 32'(resetb), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_dcb", 32'(dcb), 32'd0);

    // Single command byte with release
    e0 = sck_edges;
    send(OpDriverOutput, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(n, lo, hi);
    check("b1_busy_cycles", 32'(n), 32'd68);
    check("b1_csb_low", 32'(lo), 32'd64);
    check("b1_edges", 32'(sck_edges - e0), 32'd8);
    check("b1_csb_released", 32'(csb), 32'h3);
    expect_byte("b1", OpDriverOutput, 1'b0, 2'b10);

    // Command then two data bytes under one held chip select
    send(OpWriteRam, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle(n, lo, hi);
    check("b2_hold", 32'(hi), 32'd0);
    check("b2_cs_held_idle", 32'(csb[0]), 32'd0);
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle(n, lo, hi);
    check("b3_hold", 32'(hi), 32'd0);
    send(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle(n, lo, hi);
    check("b4_gap_release", 32'(hi), 32'd4);
    expect_byte("b2", OpWriteRam, 1'b0, 2'b10);
    expect_byte("b3", 8'hA5, 1'b1, 2'b10);
    expect_byte("b4", 8'h5A, 1'b1, 2'b10);

    // Random bytes, targets and hold/release patterns
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      dc   = 1'($urandom);
      cs   = 1'($urandom);
      last = (i == 7) ? 1'b1 : 1'($urandom);
      send(d, dc, cs, last, 1'b0);
      wait_idle(n, lo, hi);
      expect_byte("rnd", d, dc, cs ? 2'b01 : 2'b10);
    end
    check("rnd_released", 32'(csb), 32'h3);

    // Display reset pulse, without and with busy
    reset_seq(0, rlow, nid);
    check("rp_low", 32'(rlow), RstCyc);
    check("rp_total", 32'(nid >= 20 && nid <= 23), 32'd1);
    check("rp_resetb_high", 32'(resetb), 32'd1);
    reset_seq(70, rlow, nid);
    check("rpb_low", 32'(rlow), RstCyc);
    check("rpb_total", 32'(nid >= 66 && nid <= 80), 32'd1);

    // Busy stuck high with wait -> timeout
    busy = 1'b1;
    send(OpMasterAct, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle(n, lo, hi);
    check("to_cycles", 32'(n), 32'd68 + BusyTo);
    check("to_flag", 32'(timeout), 32'd1);
    expect_byte("to", OpMasterAct, 1'b0, 2'b10);
    busy = 1'b0;
    send(OpWriteRam, 1'b1, 1'b1, 1'b1, 1'b0);
    check("to_cleared", 32'(timeout), 32'd0);
    wait_idle(n, lo, hi);
    expect_byte("to_next", OpWriteRam, 1'b1, 2'b01);

    // Reset in the middle of a byte
    send(8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (slave_bits != 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 32'(slave_bits), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_csb", 32'(csb), 32'h3);
    check("mid_sck", 32'(sck), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_ready", 32'(in_ready), 32'd1);
    check("mid_no_partial", 32'(cap_data.size()), 32'd0);
    send(OpSwReset, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle(n, lo, hi);
    expect_byte("after_rst", OpSwReset, 1'b0, 2'b10);

`ifdef EINK_PASSTHRU_EN
    // Direct pin passthrough while idle
    pat = 8'h01;
    @(negedge clk);
    pt_csb = 1'b0;
    pt_dc  = 1'b1;
    pt_en  = 1'b1;
    #1;
    check("pt_ready", 32'(in_ready), 32'd0);
    check("pt_csb", 32'(csb[0]), 32'd0);
    check("pt_dcb", 32'(dcb), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      pt_mosi = pat[i];
      #1;
      check("pt_mosi", 32'(mosi), 32'(pat[i]));
      pt_sck = 1'b1;
      #1;
      check("pt_sck_hi", 32'(sck), 32'd1);
      @(negedge clk);
      pt_sck = 1'b0;
      #1;
      check("pt_sck_lo", 32'(sck), 32'd0);
      @(negedge clk);
    end
    pt_csb = 1'b1;
    pt_en  = 1'b0;
    #1;
    check("pt_off_ready", 32'(in_ready), 32'd1);
    expect_byte("pt", 8'h01, 1'b1, 2'b10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
